// File: rtl/sr_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// sr_cmd_arbiter
//
// Round-robin arbiter that serialises set/clear commands from N_REQ
// requesters onto a bank of N_FLAG SR flag cells. Each granted command drives
// its set or reset strobe for PULSE_CYC cycles. The addressed flag updates on
// the edge that ends the strobe, and then a one-cycle done pulse is issued.
//
// Parameters
//   N_REQ      number of requesters
//   N_FLAG     number of flag cells (power of two, 2..16)
//   PULSE_CYC  strobe length in cycles (1..15)
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   req    per-requester request level, held until done with own gnt bit
//   cmd    per-requester command, slice i = cmd[2i+1:2i]
//          (00 nop, 01 set, 10 clear, 11 illegal)
//   idx    per-requester flag index, slice i = idx[i*IDX_W +: IDX_W]
//   gnt    one-hot grant, valid through DRIVE and DONE
//   done   one-cycle completion pulse
//   s_bus  set strobes to the flag bank
//   r_bus  reset strobes to the flag bank
//   q      flag bank state
//   qn     complement of q
//   busy   high whenever the FSM is not idle
//   err    illegal-command pulse in the DONE cycle
//
// Configuration
//   SR_ILLEGAL_CHK_EN  when defined, a cmd of 11 raises err during DONE.
//                      When undefined, err is tied low. In both builds a cmd
//                      of 11 drives no strobe and leaves q unchanged.
// -----------------------------------------------------------------------------
module sr_cmd_arbiter #(
  parameter int N_REQ     = 4,
  parameter int N_FLAG    = 8,
  parameter int PULSE_CYC = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_REQ-1:0]                 req,
  input  logic [2*N_REQ-1:0]               cmd,
  input  logic [N_REQ*$clog2(N_FLAG)-1:0]  idx,
  output logic [N_REQ-1:0]                 gnt,
  output logic                             done,
  output logic [N_FLAG-1:0]                s_bus,
  output logic [N_FLAG-1:0]                r_bus,
  output logic [N_FLAG-1:0]                q,
  output logic [N_FLAG-1:0]                qn,
  output logic                             busy,
  output logic                             err
);

  localparam int IDX_W = $clog2(N_FLAG);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_SET = 2'b01,
    CMD_CLR = 2'b10,
    CMD_ILL = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_e;

  state_e           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] win_id;
  cmd_e             win_cmd;
  logic [IDX_W-1:0] win_idx;

  // ---------------------------------------------------------------------------
  // Round-robin pick: scan from rr_ptr upward, wrapping. The first active
  // request found wins.
  // ---------------------------------------------------------------------------
  logic             pick_vld;
  logic [PTR_W-1:0] pick_id;
  logic [N_REQ-1:0] pick_gnt;
  cmd_e             pick_cmd;
  logic [IDX_W-1:0] pick_idx;
  logic [N_FLAG-1:0] pick_mask;

  // NOTE: every variable written in an always_comb gets a default at the top.
  // Without a default, a path that does not assign the variable infers a latch.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_id  = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick_id  = PTR_W'(j);
      end
    end
  end

  always_comb begin
    pick_gnt          = '0;
    pick_gnt[pick_id] = 1'b1;
    pick_cmd          = cmd_e'(cmd[2*pick_id +: 2]);
    pick_idx          = idx[IDX_W*pick_id +: IDX_W];
    pick_mask         = '0;
    pick_mask[pick_idx] = 1'b1;
  end

  // Decoded target bit of the latched command, used for the flag update.
  logic [N_FLAG-1:0] win_mask;

  always_comb begin
    win_mask          = '0;
    win_mask[win_idx] = 1'b1;
  end

`ifdef SR_ILLEGAL_CHK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM. All outputs are registered. The strobes are loaded when the
  // FSM leaves IDLE and cleared when it leaves DRIVE, so each strobe is active
  // for exactly PULSE_CYC cycles. Only set and clear produce a strobe, so
  // s_bus and r_bus can never be high for the same bit.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking (<=) assignments.
  // This makes every register sample pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the flag bank is a handful of real flops with a defined reset
      // value, not a memory array, so it is cleared together with the control state.
      state   <= IDLE;
      rr_ptr  <= '0;
      cnt     <= '0;
      win_id  <= '0;
      win_cmd <= CMD_NOP;
      win_idx <= '0;
      q       <= '0;
      gnt     <= '0;
      done    <= 1'b0;
      s_bus   <= '0;
      r_bus   <= '0;
      busy    <= 1'b0;
`ifdef SR_ILLEGAL_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state   <= DRIVE;
            win_id  <= pick_id;
            win_cmd <= pick_cmd;
            win_idx <= pick_idx;
            cnt     <= CNT_W'(PULSE_CYC - 1);
            gnt     <= pick_gnt;
            busy    <= 1'b1;
            s_bus   <= (pick_cmd == CMD_SET) ? pick_mask : '0;
            r_bus   <= (pick_cmd == CMD_CLR) ? pick_mask : '0;
          end
        end

        DRIVE: begin
          if (cnt == '0) begin
            state <= DONE;
            s_bus <= '0;
            r_bus <= '0;
            done  <= 1'b1;
            // The flag takes its new value on the edge that ends the strobe.
            case (win_cmd)
              CMD_SET: q <= q | win_mask;
              CMD_CLR: q <= q & ~win_mask;
              default: q <= q;
            endcase
`ifdef SR_ILLEGAL_CHK_EN
            err_q <= (win_cmd == CMD_ILL);
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          gnt   <= '0;
          busy  <= 1'b0;
`ifdef SR_ILLEGAL_CHK_EN
          err_q <= 1'b0;
`endif
          // The next search starts just past the winner, so no requester can starve.
          rr_ptr <= (win_id == PTR_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign qn = ~q;

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_arbiter
//
// Self-checking bench for sr_cmd_arbiter with the default parameters
// (4 requesters, 8 flags, PULSE_CYC = 2).
//
// The bench applies a table of single-operation vectors. For each vector it
// checks the grant latency, the strobe pattern and the done cycle. When an
// operation is issued, its expected grant, q and err are pushed to a
// scoreboard queue. They are popped and compared when done is seen.
//
// Hand-written sequences cover three corner cases:
//   - round-robin order with all requests held,
//   - reset asserted during DRIVE,
//   - arbitration from a cleared pointer after that reset.
//
// A negedge monitor checks these invariants on every cycle after reset:
//   - strobe exclusivity (no bit in both s_bus and r_bus),
//   - qn == ~q,
//   - gnt is one-hot or zero,
//   - busy matches the grant state.
// -----------------------------------------------------------------------------
module tb_sr_cmd_arbiter;

  localparam int N_REQ     = 4;
  localparam int N_FLAG    = 8;
  localparam int PULSE_CYC = 2;

`ifdef SR_ILLEGAL_CHK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req;
  logic [2*N_REQ-1:0]  cmd;
  logic [N_REQ*3-1:0]  idx;
  logic [N_REQ-1:0]    gnt;
  logic                done;
  logic [N_FLAG-1:0]   s_bus;
  logic [N_FLAG-1:0]   r_bus;
  logic [N_FLAG-1:0]   q;
  logic [N_FLAG-1:0]   qn;
  logic                busy;
  logic                err;

  sr_cmd_arbiter #(
    .N_REQ    (N_REQ),
    .N_FLAG   (N_FLAG),
    .PULSE_CYC(PULSE_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .cmd  (cmd),
    .idx  (idx),
    .gnt  (gnt),
    .done (done),
    .s_bus(s_bus),
    .r_bus(r_bus),
    .q    (q),
    .qn   (qn),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  cmd;
    logic [11:0] idx;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_s;
    logic [7:0]  exp_r;
    logic [7:0]  exp_q;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] q;
    logic       err;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[10];

  // Per-cycle invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("inv_sr_exclusive", {24'd0, s_bus & r_bus}, 32'd0);
      check("inv_qn_is_not_q", {24'd0, qn}, {24'd0, ~q});
      check("inv_gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      check("inv_busy", {31'd0, busy}, {31'd0, (gnt != 4'd0)});
    end
  end

  task automatic sb_check(input string tag);
    sb_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_gnt"}, {28'd0, gnt}, {28'd0, e.gnt});
      check({tag, "_q"}, {24'd0, q}, {24'd0, e.q});
      check({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
    end
  endtask

  // Runs one operation with fixed-latency checks. Req is dropped and cmd/idx
  // are scrambled in the first DRIVE cycle. The result must still come from
  // the values latched at grant time.
  task automatic do_op(input vec_t v);
    @(negedge clk);
    req = v.req;
    cmd = v.cmd;
    idx = v.idx;
    sb.push_back(sb_t'{v.exp_gnt, v.exp_q, v.exp_err});
    @(negedge clk);
    check("op_gnt_latency", {28'd0, gnt}, {28'd0, v.exp_gnt});
    for (int p = 0; p < PULSE_CYC; p++) begin
      check("op_s_bus", {24'd0, s_bus}, {24'd0, v.exp_s});
      check("op_r_bus", {24'd0, r_bus}, {24'd0, v.exp_r});
      check("op_done_early", {31'd0, done}, 32'd0);
      if (p == 0) begin
        req = '0;
        cmd = ~v.cmd;
        idx = ~v.idx;
      end
      @(negedge clk);
    end
    check("op_done", {31'd0, done}, 32'd1);
    check("op_strobe_off", {24'd0, s_bus | r_bus}, 32'd0);
    sb_check("op");
    @(negedge clk);
    check("op_idle_done", {31'd0, done}, 32'd0);
    check("op_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b0;
    req   = '0;
    cmd   = '0;
    idx   = '0;

    // Request vectors: {req, cmd, idx, exp_gnt, exp_s_bus, exp_r_bus, exp_q, exp_err}.
    // cmd = {c3,c2,c1,c0}, idx = {i3,i2,i1,i0}.
    // The round-robin pointer after each vector is noted at the end of the line.
    vecs[0] = '{4'b0001, {2'b00, 2'b00, 2'b00, 2'b01}, {3'd0, 3'd0, 3'd0, 3'd3}, 4'b0001, 8'h08, 8'h00, 8'h08, 1'b0};  // rr 1
    vecs[1] = '{4'b0010, {2'b00, 2'b00, 2'b10, 2'b00}, {3'd0, 3'd0, 3'd3, 3'd0}, 4'b0010, 8'h00, 8'h08, 8'h00, 1'b0};  // rr 2
    vecs[2] = '{4'b0100, {2'b00, 2'b01, 2'b00, 2'b00}, {3'd0, 3'd7, 3'd0, 3'd0}, 4'b0100, 8'h80, 8'h00, 8'h80, 1'b0};  // rr 3
    vecs[3] = '{4'b1000, {2'b01, 2'b00, 2'b00, 2'b00}, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b1000, 8'h01, 8'h00, 8'h81, 1'b0};  // rr 0
    vecs[4] = '{4'b0001, {2'b10, 2'b10, 2'b10, 2'b00}, {3'd7, 3'd7, 3'd7, 3'd7}, 4'b0001, 8'h00, 8'h00, 8'h81, 1'b0};  // rr 1
    vecs[5] = '{4'b0001, {2'b00, 2'b00, 2'b00, 2'b11}, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0001, 8'h00, 8'h00, 8'h81, ILL_EN}; // rr 1
    vecs[6] = '{4'b1000, {2'b10, 2'b00, 2'b00, 2'b00}, {3'd7, 3'd0, 3'd0, 3'd0}, 4'b1000, 8'h00, 8'h80, 8'h01, 1'b0};  // rr 0
    vecs[7] = '{4'b0010, {2'b00, 2'b00, 2'b01, 2'b00}, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0010, 8'h01, 8'h00, 8'h01, 1'b0};  // rr 2
    vecs[8] = '{4'b0011, {2'b00, 2'b00, 2'b01, 2'b01}, {3'd0, 3'd0, 3'd5, 3'd4}, 4'b0001, 8'h10, 8'h00, 8'h11, 1'b0};  // rr 1
    vecs[9] = '{4'b1001, {2'b10, 2'b00, 2'b00, 2'b01}, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b1000, 8'h00, 8'h01, 8'h10, 1'b0};  // rr 0

    // Reset state.
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_s_bus", {24'd0, s_bus}, 32'd0);
    check("rst_r_bus", {24'd0, r_bus}, 32'd0);
    check("rst_q", {24'd0, q}, 32'd0);
    check("rst_qn", {24'd0, qn}, 32'hFF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) do_op(vecs[i]);

    // All four requesters held: grants rotate 0,1,2,3, then wrap to 0.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rr_seq_q_cleared", {24'd0, q}, 32'd0);
    cmd = {2'b01, 2'b01, 2'b01, 2'b01};
    idx = {3'd3, 3'd2, 3'd1, 3'd0};
    req = 4'b1111;
    sb.push_back(sb_t'{4'b0001, 8'h01, 1'b0});
    sb.push_back(sb_t'{4'b0010, 8'h03, 1'b0});
    sb.push_back(sb_t'{4'b0100, 8'h07, 1'b0});
    sb.push_back(sb_t'{4'b1000, 8'h0F, 1'b0});
    sb.push_back(sb_t'{4'b0001, 8'h0F, 1'b0});
    for (int op = 0; op < 5; op++) begin
      w = 0;
      while (done !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("rr_seq_done_seen", {31'd0, done}, 32'd1);
      if (done === 1'b1) sb_check("rr_seq");
      if (op == 4) req = '0;
      @(negedge clk);
    end
    @(negedge clk);

    // Reset during the second DRIVE cycle of a set.
    // Pointer is 1 here and q is 0x0F.
    req = 4'b0100;
    cmd = {2'b00, 2'b01, 2'b00, 2'b00};
    idx = {3'd0, 3'd6, 3'd0, 3'd0};
    @(negedge clk);
    check("abort_gnt", {28'd0, gnt}, 32'b0100);
    check("abort_s_bus1", {24'd0, s_bus}, 32'h40);
    @(negedge clk);
    check("abort_s_bus2", {24'd0, s_bus}, 32'h40);
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    check("abort_gnt_cleared", {28'd0, gnt}, 32'd0);
    check("abort_q_cleared", {24'd0, q}, 32'd0);
    check("abort_qn", {24'd0, qn}, 32'hFF);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_no_done", {31'd0, done}, 32'd0);
    check("abort_s_bus_off", {24'd0, s_bus}, 32'd0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_late_done", {31'd0, done}, 32'd0);
    end

    // Pointer must restart at 0: requesters 0 and 3 contend, and 0 wins.
    req = 4'b1001;
    cmd = {2'b00, 2'b00, 2'b00, 2'b01};
    idx = {3'd0, 3'd0, 3'd0, 3'd2};
    sb.push_back(sb_t'{4'b0001, 8'h04, 1'b0});
    @(negedge clk);
    check("post_reset_gnt", {28'd0, gnt}, 32'b0001);
    req = '0;
    repeat (PULSE_CYC) @(negedge clk);
    check("post_reset_done", {31'd0, done}, 32'd1);
    sb_check("post_reset");
    @(negedge clk);

    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
